// File: rtl/alu_pkg.sv
// Shared constants and types for the sequential ALU: mode encodings,
// flag bit positions and the handshake FSM state.
package alu_pkg;

  localparam logic [3:0] MODE_ADD  = 4'h0;
  localparam logic [3:0] MODE_ADC  = 4'h1;
  localparam logic [3:0] MODE_SUB  = 4'h2;
  localparam logic [3:0] MODE_SBB  = 4'h3;
  localparam logic [3:0] MODE_SHL1 = 4'h4;
  localparam logic [3:0] MODE_SHR1 = 4'h5;
  localparam logic [3:0] MODE_AND  = 4'h6;
  localparam logic [3:0] MODE_OR   = 4'h7;
  localparam logic [3:0] MODE_NOT  = 4'h8;
  localparam logic [3:0] MODE_XOR  = 4'h9;
  localparam logic [3:0] MODE_NAND = 4'hA;
  localparam logic [3:0] MODE_NOR  = 4'hB;
  localparam logic [3:0] MODE_SHL  = 4'hC;
  localparam logic [3:0] MODE_SHR  = 4'hD;
  localparam logic [3:0] MODE_MUL  = 4'hE;
  localparam logic [3:0] MODE_ZERO = 4'hF;

  localparam int unsigned FLAG_CARRY  = 0;
  localparam int unsigned FLAG_BORROW = 1;
  localparam int unsigned FLAG_ZERO   = 2;
  localparam int unsigned FLAG_LT     = 3;

  typedef enum logic {IDLE, RUN} state_t;

  // Modes handled by the iteration engine rather than the one-cycle datapath.
  function automatic logic is_multi(input logic [3:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) || (mode == MODE_MUL);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Multi-cycle engine: variable logical shifts (one bit per cycle) and a
// shift-add multiply (one multiplier bit per cycle). done pulses with result.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

  logic             busy;
  logic             is_mul;
  logic             dir_right;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_start;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  assign result = acc;

  // Iteration count: WIDTH for MUL, max(1, min(b, WIDTH)) for shifts.
  always_comb begin
    n_start = CNT_W'(WIDTH);
    if (op != MODE_MUL) begin
      if (b == '0) begin
        n_start = CNT_W'(1);
      end else if (b < W_LIM) begin
        n_start = CNT_W'(b);
      end
    end
  end

  // The first step runs on the start edge, so the last lands n-1 edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      is_mul    <= 1'b0;
      dir_right <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        is_mul    <= (op == MODE_MUL);
        dir_right <= (op == MODE_SHR);
        if (op == MODE_MUL) begin
          acc    <= b[0] ? a : '0;
          mcand  <= a << 1;
          mplier <= b >> 1;
        end else if (b == '0) begin
          acc <= a;
        end else if (op == MODE_SHR) begin
          acc <= a >> 1;
        end else begin
          acc <= a << 1;
        end
        cnt  <= n_start - CNT_W'(1);
        busy <= (n_start != CNT_W'(1));
        done <= (n_start == CNT_W'(1));
      end else if (busy) begin
        if (is_mul) begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end else begin
          acc <= dir_right ? (acc >> 1) : (acc << 1);
        end
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, one-cycle logic/arithmetic ops,
// a multi-cycle shift/multiply engine and an internal flag register.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       mode,
  output logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic [3:0]       flags
);

  localparam int unsigned XW = WIDTH + 1;

  state_t           state;
  logic             accept;
  logic             start;
  logic             lt_q;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;
  logic [XW-1:0]    sum;
  logic [XW-1:0]    diff;
  logic [WIDTH-1:0] res;
  logic             carry_n;
  logic             borrow_n;

  assign accept = in_valid & in_ready;
  assign start  = accept & is_multi(mode);

  alu_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (mode),
    .a      (a),
    .b      (b),
    .done   (iter_done),
    .result (iter_result)
  );

  // One-cycle datapath; ADC/SBB chain off the flag register as it stands.
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b} + XW'((mode == MODE_ADC) & flags[FLAG_CARRY]);
    diff     = {1'b0, a} - {1'b0, b} - XW'((mode == MODE_SBB) & flags[FLAG_BORROW]);
    carry_n  = flags[FLAG_CARRY];
    borrow_n = flags[FLAG_BORROW];
    res      = '0;
    case (mode)
      MODE_ADD, MODE_ADC: begin
        res     = sum[WIDTH-1:0];
        carry_n = sum[WIDTH];
      end
      MODE_SUB, MODE_SBB: begin
        res      = diff[WIDTH-1:0];
        borrow_n = diff[WIDTH];
      end
      MODE_SHL1: res = a << 1;
      MODE_SHR1: res = a >> 1;
      MODE_AND:  res = a & b;
      MODE_OR:   res = a | b;
      MODE_NOT:  res = ~a;
      MODE_XOR:  res = a ^ b;
      MODE_NAND: res = ~(a & b);
      MODE_NOR:  res = ~(a | b);
      default:   res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      c         <= '0;
      flags     <= '0;
      lt_q      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (is_multi(mode)) begin
              state    <= RUN;
              in_ready <= 1'b0;
              lt_q     <= (a < b);
            end else begin
              c                   <= res;
              flags[FLAG_CARRY]   <= carry_n;
              flags[FLAG_BORROW]  <= borrow_n;
              flags[FLAG_ZERO]    <= (res == '0);
              flags[FLAG_LT]      <= (a < b);
              out_valid           <= 1'b1;
            end
          end
        end
        RUN: begin
          if (iter_done) begin
            state            <= IDLE;
            in_ready         <= 1'b1;
            c                <= iter_result;
            flags[FLAG_ZERO] <= (iter_result == '0);
            flags[FLAG_LT]   <= lt_q;
            out_valid        <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): hand-computed results, flags,
// latencies and handshake behaviour, checked with immediate assertions.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] mode;
  logic [7:0] c;
  logic       out_valid;
  logic [3:0] flags;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .c         (c),
    .out_valid (out_valid),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present one op for exactly one edge.
  task automatic send(input logic [3:0] m, input logic [7:0] x, input logic [7:0] y);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    mode = m; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_single(input string tag, input logic [7:0] ec, input logic [3:0] ef);
    check({tag, "_ov"}, 32'(out_valid), 32'd1);
    check({tag, "_c"}, 32'(c), 32'(ec));
    check({tag, "_flags"}, 32'(flags), 32'(ef));
    tick();
    check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
  endtask

  // Count edges until out_valid; optionally offer a rogue op while busy.
  task automatic expect_multi(input string tag, input int n, input logic [7:0] ec,
                              input logic [3:0] ef, input bit rogue);
    int lat = 0;
    bit ready_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_seen = 1'b1;
      if (rogue) begin
        mode = 4'h0; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(n));
    check({tag, "_busy_ready"}, 32'(ready_seen), 32'd0);
    check({tag, "_c"}, 32'(c), 32'(ec));
    check({tag, "_flags"}, 32'(flags), 32'(ef));
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    tick();
    check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit seen_ov;
    int lat;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = '0;
    tick();
    tick();
    check("rst_c", 32'(c), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("rel_ready", 32'(in_ready), 32'd1);

    // Arithmetic and flag chaining
    send(4'h0, 8'hF0, 8'h20); expect_single("add", 8'h10, 4'h1);
    send(4'h1, 8'h01, 8'h01); expect_single("adc", 8'h03, 4'h0);
    send(4'h2, 8'h03, 8'h05); expect_single("sub", 8'hFE, 4'hA);
    send(4'h3, 8'h10, 8'h01); expect_single("sbb", 8'h0E, 4'h0);
    send(4'h2, 8'h05, 8'h05); expect_single("sub_zero", 8'h00, 4'h4);
    send(4'h0, 8'hFF, 8'h01); expect_single("add_wrap", 8'h00, 4'h5);

    // Multi-cycle shifts and multiply; carry=1 must be held throughout
    send(4'hC, 8'h81, 8'h03); expect_multi("shl3", 3, 8'h08, 4'h1, 1'b0);
    send(4'hC, 8'h81, 8'h00); expect_multi("shl0", 1, 8'h81, 4'h1, 1'b0);
    send(4'hD, 8'h81, 8'h20); expect_multi("shr32", 8, 8'h00, 4'h5, 1'b0);
    send(4'hE, 8'h0D, 8'h0B); expect_multi("mul", 8, 8'h8F, 4'h1, 1'b1);
    send(4'hE, 8'h10, 8'h10); expect_multi("mul_ovf", 8, 8'h00, 4'h5, 1'b0);

    // Remaining one-cycle ops
    send(4'h4, 8'h81, 8'h00); expect_single("shl1", 8'h02, 4'h1);
    send(4'h5, 8'h81, 8'hFF); expect_single("shr1", 8'h40, 4'h9);
    send(4'h8, 8'h5A, 8'h00); expect_single("not", 8'hA5, 4'h1);
    send(4'hA, 8'hCC, 8'hAA); expect_single("nand", 8'h77, 4'h1);
    send(4'hB, 8'hCC, 8'hAA); expect_single("nor", 8'h11, 4'h1);
    send(4'hF, 8'h01, 8'h02); expect_single("mode_f", 8'h00, 4'hD);

    // Back-to-back one-cycle ops with in_valid held high
    a = 8'hCC; b = 8'hAA; mode = 4'h6; in_valid = 1'b1;
    tick();
    check("b2b_and_ov", 32'(out_valid), 32'd1);
    check("b2b_and_c", 32'(c), 32'h88);
    mode = 4'h7;
    tick();
    check("b2b_or_ov", 32'(out_valid), 32'd1);
    check("b2b_or_c", 32'(c), 32'hEE);
    mode = 4'h9;
    tick();
    in_valid = 1'b0;
    check("b2b_xor_ov", 32'(out_valid), 32'd1);
    check("b2b_xor_c", 32'(c), 32'h66);
    check("b2b_xor_flags", 32'(flags), 32'h1);
    tick();
    check("b2b_ov_drop", 32'(out_valid), 32'd0);

    // MUL followed by an ADD accepted in the MUL out_valid cycle
    send(4'hE, 8'h0D, 8'h0B);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("mul_add_latency", 32'(lat), 32'd8);
    check("mul_add_mul_c", 32'(c), 32'h8F);
    check("mul_add_ready", 32'(in_ready), 32'd1);
    mode = 4'h0; a = 8'h02; b = 8'h03; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    expect_single("mul_add_add", 8'h05, 4'h8);

    // Reset in the middle of a MUL aborts it silently
    send(4'hE, 8'h0D, 8'h0B);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort_c", 32'(c), 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    check("abort_ov", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("abort_rel_ready", 32'(in_ready), 32'd1);
    seen_ov = out_valid;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen_ov = 1'b1;
    end
    check("abort_no_ov", 32'(seen_ov), 32'd0);
    send(4'h0, 8'h02, 8'h03); expect_single("post_abort_add", 8'h05, 4'h8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the jimbo-0 4-bit combinational ALU.
- Executes the same twelve single-cycle operations at WIDTH bits.
- Adds multi-cycle variable shifts and a shift-add multiply behind a valid/ready handshake.
- Holds the carry, borrow, zero and less-than flags in an internal register, so ADC/SBB chain without external flag feedback; sits between the register file and the writeback mux.

Parameters:
- WIDTH, 8: datapath width in bits, minimum 4.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operands and mode are presented.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for modes C/D it is the shift amount.
- mode  in  4  operation select.
- c  out  WIDTH  registered result.
- out_valid  out  1  one-cycle pulse: c and flags hold a new result.
- flags  out  4  {lt, zero, borrow, carry}, registered.

Behaviour:
- Reset: while rst=1 at a clock edge, c=0, flags=0, out_valid=0, in_ready=0, and the iteration engine goes idle.
  - in_ready=1 from the first cycle after rst deasserts.
  - rst mid-operation aborts it; no out_valid is produced for the aborted op.
- Accept: an op is accepted at a rising edge where in_valid & in_ready. a, b and mode are captured; they are ignored at all other times.
- Modes, 4'h0-4'hB, single-cycle:
  - 0 ADD, 1 ADC (+carry flag), 2 SUB, 3 SBB (-borrow flag).
  - 4 SHL1, 5 SHR1 (logical, zero fill).
  - 6 AND, 7 OR, 8 NOT a, 9 XOR, A NAND, B NOR.
  - F: result 0.
- Modes, multi-cycle:
  - C SHL by b, D SHR by b: logical.
  - E MUL: low WIDTH bits of a*b.
- Single-cycle latency: c, flags and out_valid update at the accepting edge; out_valid is high for exactly the following cycle. in_ready stays 1, so back-to-back ops are accepted every cycle.
- Multi-cycle latency: iteration count n.
  - C/D: n = max(1, min(b, WIDTH)); one bit position per cycle; b ≥ WIDTH gives 0.
  - E: n = WIDTH; shift-add, one multiplier bit per cycle.
- Multi-cycle timing:
  - FSM states: IDLE -> RUN (accepting edge) -> IDLE (edge k+n, where k is the accepting edge).
  - At edge k+n, c and flags are written and out_valid pulses.
  - in_ready=0 from after edge k until edge k+n; in_ready=1 in the out_valid cycle, allowing back-to-back accepts.
- Flags:
  - zero = (result == 0), and lt = (a < b) unsigned on captured operands; both updated by every op.
  - carry: updated only by ADD/ADC, set to the bit-WIDTH carry-out.
  - borrow: updated only by SUB/SBB, set to the borrow-out, i.e. a < b + borrow_in.
  - All other ops hold carry and borrow.
  - ADC/SBB read the flag values as they stand at the accepting edge, including a result written at that same edge by a preceding op.
- Width rules: arithmetic is modulo 2^WIDTH; MUL overflow bits are discarded, with no flag.
- Output hold: c and flags hold between results; out_valid is never high for two consecutive cycles for one op.

Decomposition:
- alu_pkg holds:
  - mode constants MODE_ADD ... MODE_MUL;
  - flag index constants FLAG_CARRY=0, FLAG_BORROW=1, FLAG_ZERO=2, FLAG_LT=3;
  - FSM state typedef {IDLE, RUN}.
- Sub-module alu_iter: the multi-cycle shift/multiply engine.
  - Inputs: start, op, a, b.
  - Outputs: done, result.
  - Owns the counter and shift/accumulate registers.
- alu_seq owns the handshake, the single-cycle datapath and the flag register.

Test Plan (WIDTH=8):
- ADD a=F0 b=20 -> next cycle: c=10, carry=1, zero=0, lt=0, out_valid 1 cycle. Then ADC a=01 b=01 -> c=03, carry=0.
- SUB a=03 b=05 -> c=FE, borrow=1, lt=1. Then SBB a=10 b=01 -> c=0E, borrow=0, carry unchanged. Then SUB 05-05 -> c=00, zero=1.
- SHL-by-b cases:
  - a=81 b=3 -> in_ready low 3 cycles, c=08 at edge k+3.
  - b=0 -> c=81 after 1 cycle.
  - SHR a=81 b=20 -> c=00, zero=1 after 8 cycles.
- MUL a=0D b=0B -> c=8F after 8 cycles, no accept while busy. Then a=10 b=10 -> c=00, zero=1.
- Back-to-back: in_valid held high with AND, OR, XOR on consecutive cycles -> three consecutive out_valid cycles with correct results; MUL followed immediately by ADD -> ADD accepted in the MUL out_valid cycle.
- Reset at cycle 3 of a MUL -> c=0, flags=0, no out_valid; in_ready=1 after release; next ADD 02+03 -> c=05.
